// File: rtl/timer_pkg.sv
// Shared types and constants for the timer control slice.
package timer_pkg;

  localparam int unsigned DIV_MAX = 8;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_LO   = 2'b01;
  localparam logic [1:0] SEL_HI   = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Power-of-two prescaler: raises tick on the active cycle in which the count
// has reached 2^min(div_val, DIV_MAX) - 1.
module timer_prescaler #(
  parameter int unsigned DIV_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       active,
  input  logic       clr,
  input  logic       div_en,
  input  logic [3:0] div_val,
  output logic       tick
);

  logic [7:0] count;
  logic [3:0] exp_eff;
  logic [8:0] limit;
  logic       at_limit;

  // Compare with >= so a shrinking div_val mid-period fires straight away.
  always_comb begin
    exp_eff  = (32'(div_val) > DIV_MAX) ? 4'(DIV_MAX) : div_val;
    limit    = (9'd1 << exp_eff) - 9'd1;
    at_limit = ({1'b0, count} >= limit);
    tick     = active && (!div_en || at_limit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr || !div_en) begin
      count <= '0;
    end else if (active) begin
      count <= at_limit ? '0 : count + 8'd1;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Timer control sequencer: prescaled count enable, clear strobe, two-beat
// 64-bit load, debug halt and sticky compare-match interrupt.
module timer_ctrl #(
  parameter int unsigned CNT_W   = 64,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DIV_MAX = timer_pkg::DIV_MAX
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              timer_en,
  input  logic              div_en,
  input  logic [3:0]        div_val,
  input  logic              dbg_mode,
  input  logic              halt_req,
  input  logic              clear_req,
  input  logic              load_req,
  input  logic [CNT_W-1:0]  load_data,
  input  logic [CNT_W-1:0]  cnt_val,
  input  logic [CNT_W-1:0]  cmp_val,
  input  logic              int_en,
  input  logic              int_clr,
  output logic              cnt_en,
  output logic              counter_clear,
  output logic [DATA_W-1:0] counter_write_data,
  output logic [1:0]        counter_write_sel,
  output logic              load_busy,
  output logic              load_done,
  output logic              halt_ack,
  output logic              int_st,
  output logic              tim_int
);

  import timer_pkg::*;

  state_t             state, next_state;
  logic [CNT_W-1:0]   hold, hold_d;
  logic               halted;
  logic               halt_d;
  logic               load_start;
  logic               active;
  logic               tick;
  logic [1:0]         sel_d;
  logic [DATA_W-1:0]  data_d;
  logic               busy_d;
  logic               done_d;
  logic               int_d;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (clear_req) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (load_req) next_state = WR_LO;
        WR_LO:   next_state = WR_HI;
        WR_HI:   next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Outputs are decoded from next_state so the write beats land in the same
  // cycle the FSM enters WR_LO/WR_HI; halt_d (not the halted flop) gates
  // counting so cnt_en is never high alongside halt_ack.
  always_comb begin
    load_start = (state == IDLE) && load_req && !clear_req;
    halt_d     = halt_req && dbg_mode;
    active     = timer_en && !halt_d && (state == IDLE) && !load_start && !clear_req;
    hold_d     = load_start ? load_data : hold;
    sel_d      = SEL_NONE;
    data_d     = '0;
    busy_d     = 1'b0;
    unique case (next_state)
      WR_LO: begin
        sel_d  = SEL_LO;
        data_d = hold_d[DATA_W-1:0];
        busy_d = 1'b1;
      end
      WR_HI: begin
        sel_d  = SEL_HI;
        data_d = hold_d[CNT_W-1:DATA_W];
        busy_d = 1'b1;
      end
      default: ;
    endcase
    done_d = (state == WR_HI) && !clear_req;
    int_d  = (cnt_val == cmp_val) || (int_st && !int_clr);
  end

  timer_prescaler #(
    .DIV_MAX (DIV_MAX)
  ) u_presc (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .active  (active),
    .clr     (clear_req || !timer_en),
    .div_en  (div_en),
    .div_val (div_val),
    .tick    (tick)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hold               <= '0;
      halted             <= 1'b0;
      cnt_en             <= 1'b0;
      counter_clear      <= 1'b0;
      counter_write_data <= '0;
      counter_write_sel  <= SEL_NONE;
      load_busy          <= 1'b0;
      load_done          <= 1'b0;
      int_st             <= 1'b0;
      tim_int            <= 1'b0;
    end else begin
      hold               <= hold_d;
      halted             <= halt_d;
      cnt_en             <= tick;
      counter_clear      <= clear_req;
      counter_write_data <= data_d;
      counter_write_sel  <= sel_d;
      load_busy          <= busy_d;
      load_done          <= done_d;
      int_st             <= int_d;
      tim_int            <= int_d && int_en;
    end
  end

  assign halt_ack = halted;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: a vector table for load/clear/enable
// behaviour plus hand sequences for prescaler, halt, compare and reset.
module tb_timer_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        timer_en, div_en, dbg_mode, halt_req, clear_req, load_req;
  logic [3:0]  div_val;
  logic [63:0] load_data, cnt_val, cmp_val;
  logic        int_en, int_clr;
  logic        cnt_en, counter_clear, load_busy, load_done, halt_ack, int_st, tim_int;
  logic [31:0] counter_write_data;
  logic [1:0]  counter_write_sel;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  timer_ctrl #(
    .CNT_W   (64),
    .DATA_W  (32),
    .DIV_MAX (8)
  ) dut (
    .sys_clk            (sys_clk),
    .sys_rst            (sys_rst),
    .timer_en           (timer_en),
    .div_en             (div_en),
    .div_val            (div_val),
    .dbg_mode           (dbg_mode),
    .halt_req           (halt_req),
    .clear_req          (clear_req),
    .load_req           (load_req),
    .load_data          (load_data),
    .cnt_val            (cnt_val),
    .cmp_val            (cmp_val),
    .int_en             (int_en),
    .int_clr            (int_clr),
    .cnt_en             (cnt_en),
    .counter_clear      (counter_clear),
    .counter_write_data (counter_write_data),
    .counter_write_sel  (counter_write_sel),
    .load_busy          (load_busy),
    .load_done          (load_done),
    .halt_ack           (halt_ack),
    .int_st             (int_st),
    .tim_int            (tim_int)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string       name;
    logic        ten;
    logic        lreq;
    logic [63:0] ldata;
    logic        clr;
    logic        e_cnt;
    logic        e_clear;
    logic [1:0]  e_sel;
    logic [31:0] e_wdata;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string name, logic ten, logic lreq, logic [63:0] ldata,
                              logic clr, logic e_cnt, logic e_clear, logic [1:0] e_sel,
                              logic [31:0] e_wdata, logic e_busy, logic e_done);
    vec_t v;
    v.name = name; v.ten = ten; v.lreq = lreq; v.ldata = ldata; v.clr = clr;
    v.e_cnt = e_cnt; v.e_clear = e_clear; v.e_sel = e_sel; v.e_wdata = e_wdata;
    v.e_busy = e_busy; v.e_done = e_done;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    timer_en = 0; div_en = 0; div_val = 0; dbg_mode = 0; halt_req = 0;
    clear_req = 0; load_req = 0; load_data = '0; cnt_val = '0; cmp_val = '1;
    int_en = 0; int_clr = 0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".cnt_en"}, 64'(cnt_en), 0);
    chk({nm, ".clear"},  64'(counter_clear), 0);
    chk({nm, ".wdata"},  64'(counter_write_data), 0);
    chk({nm, ".sel"},    64'(counter_write_sel), 0);
    chk({nm, ".busy"},   64'(load_busy), 0);
    chk({nm, ".done"},   64'(load_done), 0);
    chk({nm, ".halt"},   64'(halt_ack), 0);
    chk({nm, ".int_st"}, 64'(int_st), 0);
    chk({nm, ".tim_int"},64'(tim_int), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    chk_all_zero("reset");

    // Vector table: one row per clock, inputs applied before the edge.
    tbl.push_back(mk("en0",          1, 0, 64'h0,                   0, 1, 0, 2'b00, 32'h0,         0, 0));
    tbl.push_back(mk("en1",          1, 0, 64'h0,                   0, 1, 0, 2'b00, 32'h0,         0, 0));
    tbl.push_back(mk("ld_lo",        1, 1, 64'h1234_5678_9ABC_DEF0, 0, 0, 0, 2'b01, 32'h9ABC_DEF0, 1, 0));
    tbl.push_back(mk("ld_hi_ign",    1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 2'b10, 32'h1234_5678, 1, 0));
    tbl.push_back(mk("ld_done",      1, 0, 64'h0,                   0, 0, 0, 2'b00, 32'h0,         0, 1));
    tbl.push_back(mk("post_ld",      1, 0, 64'h0,                   0, 1, 0, 2'b00, 32'h0,         0, 0));
    tbl.push_back(mk("ld2_lo",       1, 1, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0, 0, 2'b01, 32'hCCCC_DDDD, 1, 0));
    tbl.push_back(mk("clr_abort",    1, 0, 64'h0,                   1, 0, 1, 2'b00, 32'h0,         0, 0));
    tbl.push_back(mk("abort_nodone", 1, 0, 64'h0,                   0, 1, 0, 2'b00, 32'h0,         0, 0));
    tbl.push_back(mk("abort_idle",   1, 0, 64'h0,                   0, 1, 0, 2'b00, 32'h0,         0, 0));
    tbl.push_back(mk("clr_and_ld",   1, 1, 64'h5555_6666_7777_8888, 1, 0, 1, 2'b00, 32'h0,         0, 0));
    tbl.push_back(mk("ld_dropped",   1, 0, 64'h0,                   0, 1, 0, 2'b00, 32'h0,         0, 0));
    tbl.push_back(mk("disabled",     0, 0, 64'h0,                   0, 0, 0, 2'b00, 32'h0,         0, 0));

    foreach (tbl[i]) begin
      timer_en = tbl[i].ten; load_req = tbl[i].lreq;
      load_data = tbl[i].ldata; clear_req = tbl[i].clr;
      step();
      chk({tbl[i].name, ".cnt_en"},  64'(cnt_en),             64'(tbl[i].e_cnt));
      chk({tbl[i].name, ".clear"},   64'(counter_clear),      64'(tbl[i].e_clear));
      chk({tbl[i].name, ".sel"},     64'(counter_write_sel),  64'(tbl[i].e_sel));
      chk({tbl[i].name, ".wdata"},   64'(counter_write_data), 64'(tbl[i].e_wdata));
      chk({tbl[i].name, ".busy"},    64'(load_busy),          64'(tbl[i].e_busy));
      chk({tbl[i].name, ".done"},    64'(load_done),          64'(tbl[i].e_done));
      chk({tbl[i].name, ".halt"},    64'(halt_ack),           0);
      chk({tbl[i].name, ".int_st"},  64'(int_st),             0);
    end
    idle_inputs();

    // Prescaler div_val=3: period 8.
    timer_en = 1; div_en = 1; div_val = 3;
    for (int i = 0; i < 24; i++) begin
      step();
      chk("div3", 64'(cnt_en), 64'((i % 8) == 7));
    end

    // div_val=12 clamps to 8: period 256.
    div_en = 0; step();
    div_en = 1; div_val = 12;
    for (int i = 0; i < 512; i++) begin
      step();
      chk("div12_clamp", 64'(cnt_en), 64'((i % 256) == 255));
    end

    // div_val 3 -> 1 with count at 5 ticks on the next edge.
    div_en = 0; step();
    div_en = 1; div_val = 3;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("div_sw_pre", 64'(cnt_en), 0);
    end
    div_val = 1;
    step(); chk("div_sw_tick", 64'(cnt_en), 1);
    step(); chk("div_sw_gap",  64'(cnt_en), 0);
    step(); chk("div_sw_next", 64'(cnt_en), 1);

    // Clear resets the prescaler count mid-period.
    div_en = 0; step();
    div_en = 1; div_val = 3;
    repeat (4) step();
    clear_req = 1;
    step();
    chk("presc_clr.clear", 64'(counter_clear), 1);
    chk("presc_clr.cnt_en", 64'(cnt_en), 0);
    clear_req = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("presc_after_clr", 64'(cnt_en), 64'(i == 7));
    end

    // Halt freezes the prescaler count at 3, then resumes from it.
    div_en = 0; step();
    div_en = 1; div_val = 3;
    repeat (3) step();
    dbg_mode = 1; halt_req = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("halt.ack", 64'(halt_ack), 1);
      chk("halt.cnt_en", 64'(cnt_en), 0);
    end
    halt_req = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) chk("halt_rel.ack", 64'(halt_ack), 0);
      chk("halt_resume", 64'(cnt_en), 64'(i == 4));
    end
    div_en = 0; dbg_mode = 0; halt_req = 1;
    step();
    chk("halt_nodbg.ack", 64'(halt_ack), 0);
    chk("halt_nodbg.cnt_en", 64'(cnt_en), 1);
    step();
    chk("halt_nodbg.ack2", 64'(halt_ack), 0);
    idle_inputs();

    // Compare-match interrupt.
    cmp_val = 64'h10; int_en = 1;
    cnt_val = 64'h0F; step();
    chk("cmp_pre.int_st", 64'(int_st), 0);
    chk("cmp_pre.tim_int", 64'(tim_int), 0);
    cnt_val = 64'h10; step();
    chk("cmp_hit.int_st", 64'(int_st), 1);
    chk("cmp_hit.tim_int", 64'(tim_int), 1);
    int_clr = 1; step();
    chk("cmp_setwins", 64'(int_st), 1);
    int_clr = 0; cnt_val = 64'h11; step();
    chk("cmp_sticky", 64'(int_st), 1);
    int_clr = 1; step();
    chk("cmp_cleared.int_st", 64'(int_st), 0);
    chk("cmp_cleared.tim_int", 64'(tim_int), 0);
    int_clr = 0; int_en = 0; cnt_val = 64'h10; step();
    chk("cmp_masked.int_st", 64'(int_st), 1);
    chk("cmp_masked.tim_int", 64'(tim_int), 0);
    int_en = 1; step();
    chk("cmp_unmask.tim_int", 64'(tim_int), 1);
    cnt_val = 64'h11; int_clr = 1; step();
    chk("cmp_clr2", 64'(int_st), 0);
    int_clr = 0; cmp_val = 64'h1_0000_0010; cnt_val = 64'h10; step();
    chk("cmp_full64", 64'(int_st), 0);
    idle_inputs();

    // Asynchronous reset in the middle of a load.
    load_req = 1; load_data = 64'hDEAD_BEEF_0BAD_F00D;
    step();
    chk("rst_ld.sel", 64'(counter_write_sel), 1);
    chk("rst_ld.wdata", 64'(counter_write_data), 64'h0BAD_F00D);
    load_req = 0;
    #2 sys_rst = 1'b1;
    #1;
    chk("rst_mid.sel", 64'(counter_write_sel), 0);
    chk("rst_mid.busy", 64'(load_busy), 0);
    chk("rst_mid.wdata", 64'(counter_write_data), 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    step();
    chk("rst_after.sel", 64'(counter_write_sel), 0);
    step();
    chk("rst_after.done", 64'(load_done), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Control sequencer for the 64-bit timer counter.
- Generates the prescaled count-enable tick and the clear pulse.
- Performs atomic 64-bit loads as two sequenced 32-bit write cycles.
- Handles debug halt and the compare-match interrupt; sits between the register interface and the counter datapath.

Parameters:
- CNT_W, 64, counter width; must be 2*DATA_W.
- DATA_W, 32, counter write-port width.
- DIV_MAX, 8, largest prescaler exponent honoured.

Ports:
- sys_clk  in  1  system clock; one clock domain.
- sys_rst  in  1  asynchronous reset, active-high.
- timer_en  in  1  counting enable.
- div_en  in  1  1 = prescaler active; 0 = tick every cycle.
- div_val  in  4  prescaler exponent; tick period 2^div_val.
- dbg_mode  in  1  debug mode qualifier.
- halt_req  in  1  halt request, honoured only when dbg_mode=1.
- clear_req  in  1  single-cycle counter clear request.
- load_req  in  1  single-cycle 64-bit load request.
- load_data  in  64  load value, sampled with load_req.
- cnt_val  in  64  current counter value from the datapath.
- cmp_val  in  64  compare value.
- int_en  in  1  interrupt output enable.
- int_clr  in  1  clear for int_st.
- cnt_en  out  1  increment strobe to the counter.
- counter_clear  out  1  clear strobe to the counter.
- counter_write_data  out  32  write data to the counter.
- counter_write_sel  out  2  01 = low word, 10 = high word, 00 = none.
- load_busy  out  1  load sequence in progress.
- load_done  out  1  one-cycle pulse when the load completes.
- halt_ack  out  1  counter is halted.
- int_st  out  1  sticky compare-match status.
- tim_int  out  1  interrupt line, equal to int_st & int_en.

Behaviour:
- All outputs are registered. On reset every output is 0, FSM state = IDLE, prescaler count = 0.
- FSM states: IDLE, WR_LO, WR_HI.
  - IDLE -> WR_LO when load_req=1; load_data is captured into a 64-bit holding register.
  - WR_LO: counter_write_sel=01, counter_write_data=hold[31:0]; next state WR_HI.
  - WR_HI: counter_write_sel=10, counter_write_data=hold[63:32]; next state IDLE; load_done pulses in the cycle after WR_HI.
  - load_busy=1 in WR_LO and WR_HI.
  - counter_write_data=0 whenever counter_write_sel=00.
  - load_req while busy is ignored (dropped, not queued).
- Load latency: load_req in cycle N gives WR_LO in N+1, WR_HI in N+2, load_done in N+3.
- clear_req has the highest priority:
  - counter_clear=1 in the next cycle.
  - An in-progress load is aborted: FSM returns to IDLE, no load_done.
  - The prescaler count resets to 0.
  - clear_req together with load_req: clear wins and the load is dropped.
- Halt: halted register <= halt_req & dbg_mode; halt_ack = halted. Counting stops while halted; the prescaler count holds its value.
- Counting is active only when timer_en=1, not halted, state=IDLE, and no clear is pending.
- Prescaler:
  - Limit L = 2^min(div_val, DIV_MAX) - 1.
  - div_en=0: cnt_en=1 every active cycle.
  - div_en=1: an 8-bit count increments each active cycle; when count >= L, cnt_en pulses for one cycle and the count returns to 0.
  - A change of div_val mid-period takes effect immediately through the >= comparison.
  - Timing: cnt_en rises one cycle after the count reaches L.
- When timer_en=0 or div_en=0, the prescaler count is forced to 0.
- cnt_en is forced to 0 during load, during clear, and while halted. This keeps the two load halves from being separated by an increment.
- Compare:
  - int_st is set in the cycle after cnt_val == cmp_val (full 64-bit compare).
  - int_clr clears int_st.
  - Set and clear in the same cycle: set wins.
  - While the counter is held at the match value, int_st re-sets after a clear.
- Counter wrap from 0xFFFF_FFFF_FFFF_FFFF to 0 is handled by the datapath. The controller applies no special rule to it.
- Reset mid-load: sequence abandoned, counter_write_sel=00 immediately, holding register = 0.

Decomposition:
- Shared package timer_pkg holds:
  - FSM state encoding (IDLE=2'd0, WR_LO=2'd1, WR_HI=2'd2).
  - Write-select constants SEL_NONE=2'b00, SEL_LO=2'b01, SEL_HI=2'b10.
  - DIV_MAX.
- One natural sub-module, timer_prescaler: input active, div_en, div_val; output tick; internal 8-bit count with sync clear.
- The FSM, halt logic and interrupt logic stay in timer_ctrl.

Test Plan:
- Reset, then timer_en=1, div_en=0 -> cnt_en=1 every cycle starting one cycle after enable; all other outputs 0.
- div_en=1, div_val=3 -> cnt_en pulses every 8 cycles. div_val=12 -> period 256 (clamped to DIV_MAX). Switching div_val 3->1 mid-period with count=5 -> tick on the next cycle.
- load_req with load_data=0x1234_5678_9ABC_DEF0 -> sel=01 with data 0x9ABC_DEF0, then sel=10 with data 0x1234_5678, then load_done; cnt_en=0 for those 3 cycles; a second load_req during WR_LO is ignored.
- clear_req asserted during WR_LO -> counter_clear=1 next cycle, sel returns to 00, no load_done, prescaler count = 0.
- cmp_val=0x10 with cnt_val stepping 0x0F->0x10 -> int_st=1 the following cycle; tim_int=1 only if int_en=1; int_clr together with match keeps int_st=1; int_clr after cnt_val=0x11 -> int_st=0.
- dbg_mode=1, halt_req=1 -> halt_ack=1 next cycle, cnt_en stays 0, prescaler count frozen. Release -> counting resumes from the frozen count. halt_req with dbg_mode=0 -> no halt.
